// File: rtl/icache_pkg.sv
// Shared types and constants for the direct-mapped instruction cache:
// FSM states, address field widths and the refill address helper.
package icache_pkg;

  localparam int ADDR_W   = 16;
  localparam int WORD_W   = 16;
  localparam int OFFSET_W = 2;
  localparam int INDEX_W  = 5;
  localparam int LINE_W   = ADDR_W - OFFSET_W - 1;
  localparam int TAG_W    = LINE_W - INDEX_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL0,
    S_FILL1,
    S_FILL2,
    S_FILL3,
    S_DONE
  } state_t;

  // line = {tag, index}; k = word within the line
  function automatic logic [ADDR_W-1:0] fill_addr(
    input logic [LINE_W-1:0]   line,
    input logic [OFFSET_W-1:0] k
  );
    return {line, k, 1'b0};
  endfunction

endpackage

// File: rtl/icache_line_store.sv
// Valid/tag/data arrays for the cache: one combinational read port
// (index -> valid, tag, whole line) and one write port (word write,
// set-valid with tag, clear-valid). Valid bits clear on i_rst.
module icache_line_store #(
  parameter int INDEX_W  = icache_pkg::INDEX_W,
  parameter int TAG_BITS = icache_pkg::TAG_W,
  parameter int WORDS    = 4
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic [INDEX_W-1:0]           i_rd_index,
  output logic                         o_rd_valid,
  output logic [TAG_BITS-1:0]          o_rd_tag,
  output logic [WORDS*16-1:0]          o_rd_line,
  input  logic                         i_wr_en,
  input  logic [INDEX_W-1:0]           i_wr_index,
  input  logic [1:0]                   i_wr_word,
  input  logic [15:0]                  i_wr_data,
  input  logic                         i_set_valid,
  input  logic [TAG_BITS-1:0]          i_set_tag,
  input  logic                         i_clr_valid,
  input  logic [INDEX_W-1:0]           i_clr_index
);
  import icache_pkg::*;

  localparam int LINES = 1 << INDEX_W;

  logic [LINES-1:0]    r_valid;
  logic [TAG_BITS-1:0] r_tag  [LINES];
  logic [WORD_W-1:0]   r_data [LINES][WORDS];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_valid <= '0;
    end else begin
      if (i_clr_valid) r_valid[i_clr_index] <= 1'b0;
      if (i_set_valid) r_valid[i_wr_index]  <= 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_wr_en)     r_data[i_wr_index][i_wr_word] <= i_wr_data;
    if (i_set_valid) r_tag[i_wr_index] <= i_set_tag;
  end

  assign o_rd_valid = r_valid[i_rd_index];
  assign o_rd_tag   = r_tag[i_rd_index];

  always_comb begin
    o_rd_line = '0;
    for (int w = 0; w < WORDS; w++)
      o_rd_line[w*WORD_W +: WORD_W] = r_data[i_rd_index][w];
  end

endmodule

// File: rtl/icache_direct.sv
// Direct-mapped read-only instruction cache: same-cycle hits, 4-word
// line refill on miss. Ports: fetch side (Addr/Rd -> DataOut/Done/
// Stall/CacheHit/err) and memory side (mem_rd/mem_addr <- mem_data/
// mem_valid/mem_err). Outputs are forced low while rst is high.
module icache_direct #(
  parameter int INDEX_W = 5,
  parameter int WORDS   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] Addr,
  input  logic        Rd,
  output logic [15:0] DataOut,
  output logic        Done,
  output logic        Stall,
  output logic        CacheHit,
  output logic        err,
  output logic        mem_rd,
  output logic [15:0] mem_addr,
  input  logic [15:0] mem_data,
  input  logic        mem_valid,
  input  logic        mem_err
);
  import icache_pkg::*;

  localparam int TAG_BITS = LINE_W - INDEX_W;

  state_t              r_state;
  logic [LINE_W-1:0]   r_req_line;
  logic [OFFSET_W-1:0] r_req_off;
  logic                r_fill_err;

  logic [TAG_BITS-1:0] w_addr_tag;
  logic [TAG_BITS-1:0] w_req_tag;
  logic [TAG_BITS-1:0] w_line_tag;
  logic [INDEX_W-1:0]  w_addr_idx;
  logic [INDEX_W-1:0]  w_req_idx;
  logic [INDEX_W-1:0]  w_idx;
  logic [WORDS*16-1:0] w_line;
  logic [WORD_W-1:0]   w_word;
  logic [OFFSET_W-1:0] w_off;
  logic [OFFSET_W-1:0] w_k;
  logic                w_line_valid;
  logic                w_idle;
  logic                w_fill;
  logic                w_hit;
  logic                w_miss;
  logic                w_wr_en;
  logic                w_set_valid;
  logic                w_clr_valid;

  assign w_addr_tag = Addr[15 -: TAG_BITS];
  assign w_addr_idx = Addr[3 +: INDEX_W];
  assign w_req_tag  = r_req_line[LINE_W-1 -: TAG_BITS];
  assign w_req_idx  = r_req_line[INDEX_W-1:0];

  assign w_idle = (r_state == S_IDLE);
  assign w_fill = (r_state == S_FILL0) || (r_state == S_FILL1) ||
                  (r_state == S_FILL2) || (r_state == S_FILL3);

  // Lookups use the live PC in IDLE, the latched request otherwise.
  assign w_idx  = w_idle ? w_addr_idx : w_req_idx;
  assign w_off  = w_idle ? Addr[2:1] : r_req_off;
  assign w_word = w_line[{w_off, 4'b0000} +: WORD_W];

  assign w_hit  = w_line_valid && (w_line_tag == w_addr_tag);
  assign w_miss = w_idle && Rd && !Addr[0] && !w_hit;

  always_comb begin
    case (r_state)
      S_FILL1: w_k = 2'd1;
      S_FILL2: w_k = 2'd2;
      S_FILL3: w_k = 2'd3;
      default: w_k = 2'd0;
    endcase
  end

  // The victim line is invalidated when its refill starts, so a
  // refill that ends in error never leaves stale words marked valid.
  assign w_wr_en     = !rst && w_fill && mem_valid;
  assign w_set_valid = !rst && (r_state == S_DONE) && !r_fill_err;
  assign w_clr_valid = !rst && w_miss;

  icache_line_store #(
    .INDEX_W  (INDEX_W),
    .TAG_BITS (TAG_BITS),
    .WORDS    (WORDS)
  ) u_store (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_rd_index  (w_idx),
    .o_rd_valid  (w_line_valid),
    .o_rd_tag    (w_line_tag),
    .o_rd_line   (w_line),
    .i_wr_en     (w_wr_en),
    .i_wr_index  (w_req_idx),
    .i_wr_word   (w_k),
    .i_wr_data   (mem_data),
    .i_set_valid (w_set_valid),
    .i_set_tag   (w_req_tag),
    .i_clr_valid (w_clr_valid),
    .i_clr_index (w_addr_idx)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_req_line <= '0;
      r_req_off  <= '0;
      r_fill_err <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_miss) begin
            r_req_line <= Addr[15:3];
            r_req_off  <= Addr[2:1];
            r_state    <= S_FILL0;
          end
        end
        S_FILL0: begin
          if (mem_valid) begin
            r_fill_err <= r_fill_err | mem_err;
            r_state    <= S_FILL1;
          end
        end
        S_FILL1: begin
          if (mem_valid) begin
            r_fill_err <= r_fill_err | mem_err;
            r_state    <= S_FILL2;
          end
        end
        S_FILL2: begin
          if (mem_valid) begin
            r_fill_err <= r_fill_err | mem_err;
            r_state    <= S_FILL3;
          end
        end
        S_FILL3: begin
          if (mem_valid) begin
            r_fill_err <= r_fill_err | mem_err;
            r_state    <= S_DONE;
          end
        end
        S_DONE: begin
          r_fill_err <= 1'b0;
          r_state    <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    DataOut  = '0;
    Done     = 1'b0;
    Stall    = 1'b0;
    CacheHit = 1'b0;
    err      = 1'b0;
    mem_rd   = 1'b0;
    mem_addr = '0;
    if (!rst) begin
      case (r_state)
        S_IDLE: begin
          if (Rd) begin
            if (Addr[0]) begin
              err  = 1'b1;
              Done = 1'b1;
            end else if (w_hit) begin
              Done     = 1'b1;
              CacheHit = 1'b1;
              DataOut  = w_word;
            end else begin
              Stall = 1'b1;
            end
          end
        end
        S_FILL0, S_FILL1, S_FILL2, S_FILL3: begin
          mem_rd   = 1'b1;
          mem_addr = fill_addr(r_req_line, w_k);
          Stall    = 1'b1;
        end
        S_DONE: begin
          Done    = 1'b1;
          DataOut = w_word;
          err     = r_fill_err;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_icache_direct.sv
// Bench for icache_direct: directed scenarios with literal expectations
// plus a randomized phase checked every cycle against a cache model.
module tb_icache_direct;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] Addr = '0;
  logic        Rd = 1'b0;
  logic [15:0] DataOut;
  logic        Done, Stall, CacheHit, err, mem_rd;
  logic [15:0] mem_addr;
  logic [15:0] mem_data = '0;
  logic        mem_valid = 1'b0;
  logic        mem_err = 1'b0;

  int checks = 0;
  int errors = 0;

  logic [15:0] mem [32768];
  int lat = 1;
  int err_word = -1;
  bit rand_mode = 1'b0;
  int rcnt = 0;

  icache_direct #(.INDEX_W(5), .WORDS(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .Addr      (Addr),
    .Rd        (Rd),
    .DataOut   (DataOut),
    .Done      (Done),
    .Stall     (Stall),
    .CacheHit  (CacheHit),
    .err       (err),
    .mem_rd    (mem_rd),
    .mem_addr  (mem_addr),
    .mem_data  (mem_data),
    .mem_valid (mem_valid),
    .mem_err   (mem_err)
  );

  always #5 clk = ~clk;

  // backing memory: answers the lat-th cycle of each mem_rd word
  always @(posedge clk) begin
    #2;
    if (mem_rd) begin
      rcnt++;
      if (rcnt >= lat) begin
        mem_valid = 1'b1;
        mem_data  = mem[mem_addr[15:1]];
        if (rand_mode) mem_err = ($urandom_range(0, 15) == 0);
        else mem_err = (int'(mem_addr[2:1]) == err_word);
        rcnt = 0;
        if (rand_mode) lat = $urandom_range(1, 3);
      end else begin
        mem_valid = 1'b0;
        mem_err   = 1'b0;
      end
    end else begin
      rcnt      = 0;
      mem_valid = rand_mode && ($urandom_range(0, 3) == 0);
      mem_data  = 16'($urandom);
      mem_err   = mem_valid && ($urandom_range(0, 1) == 1);
    end
  end

  // reference model: cache contents plus one outstanding refill
  bit          m_valid [32];
  logic [7:0]  m_tag   [32];
  bit          busy = 1'b0;
  logic [15:0] req = '0;
  int          cnt = 0;
  bit          ferr = 1'b0;

  always @(negedge clk) begin : model
    logic [36:0] exp_v, got_v;
    logic [15:0] e_data, e_maddr;
    logic        e_done, e_stall, e_hit, e_err, e_mrd;
    logic [4:0]  ix;
    bit          hit;
    e_data = '0; e_maddr = '0;
    e_done = 0; e_stall = 0; e_hit = 0; e_err = 0; e_mrd = 0;
    ix  = Addr[7:3];
    hit = m_valid[ix] && (m_tag[ix] == Addr[15:8]);
    if (rst) begin
    end else if (!busy) begin
      if (Rd) begin
        if (Addr[0]) begin
          e_err = 1; e_done = 1;
        end else if (hit) begin
          e_done = 1; e_hit = 1; e_data = mem[Addr[15:1]];
        end else begin
          e_stall = 1;
        end
      end
    end else if (cnt < 4) begin
      e_mrd = 1; e_stall = 1;
      e_maddr = {req[15:3], cnt[1:0], 1'b0};
    end else begin
      e_done = 1; e_err = ferr; e_data = mem[req[15:1]];
    end
    exp_v = {e_done, e_stall, e_hit, e_err, e_mrd, e_maddr, e_data};
    got_v = {Done, Stall, CacheHit, err, mem_rd, mem_addr, DataOut};
    checks++;
    if (got_v !== exp_v) begin
      errors++;
      $display("FAIL model t=%0t {done,stall,hit,err,mrd,maddr,data} got %h expected %h",
               $time, got_v, exp_v);
    end
    if (rst) begin
      for (int i = 0; i < 32; i++) m_valid[i] = 0;
      busy = 0; ferr = 0;
    end else if (!busy) begin
      if (Rd && !Addr[0] && !hit) begin
        busy = 1; req = Addr; cnt = 0; ferr = 0;
        m_valid[ix] = 0;
      end
    end else if (cnt < 4) begin
      if (mem_valid) begin
        ferr = ferr | mem_err;
        cnt++;
      end
    end else begin
      if (!ferr) begin
        m_valid[req[7:3]] = 1;
        m_tag[req[7:3]]   = req[15:8];
      end
      busy = 0;
    end
  end

  task automatic chk(input string name, input logic [39:0] got,
                     input logic [39:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (Done !== 1'b1 && n < 200) begin
      adv();
      smp();
      n++;
    end
    chk(name, 40'(Done), 40'd1);
  endtask

  function automatic logic [15:0] rand_addr();
    logic [7:0] tg;
    logic [4:0] ix;
    logic [1:0] off;
    logic       lsb;
    case ($urandom_range(0, 2))
      0:       tg = 8'h00;
      1:       tg = 8'h01;
      default: tg = 8'hA5;
    endcase
    ix  = 5'($urandom_range(0, 7));
    off = 2'($urandom_range(0, 3));
    lsb = ($urandom_range(0, 19) == 0);
    return {tg, ix, off, lsb};
  endfunction

  initial begin
    for (int i = 0; i < 32768; i++) mem[i] = 16'($urandom);
    mem[0] = 16'h1111; mem[1] = 16'h2222;
    mem[2] = 16'h3333; mem[3] = 16'h4444;
    mem[16'h0080] = 16'hA0A0;
    mem[16'h0180] = 16'hC0C0;

    rst = 1; Rd = 0; Addr = 0;
    repeat (3) adv();
    rst = 0;
    smp();
    chk("reset_idle",
        40'({Done, Stall, CacheHit, err, mem_rd, mem_addr, DataOut}), 40'd0);

    // cold miss, N=1
    adv(); Rd = 1; Addr = 16'h0000; smp();
    chk("cold_stall", 40'({Stall, Done}), 40'b10);
    for (int k = 0; k < 4; k++) begin
      adv(); smp();
      chk("cold_maddr", 40'({mem_rd, mem_addr}), 40'({1'b1, 16'(2 * k)}));
    end
    adv(); smp();
    chk("cold_done", 40'({Done, CacheHit, err, DataOut}),
        40'({3'b100, 16'h1111}));

    // hit after fill
    adv(); Addr = 16'h0004; smp();
    chk("hit", 40'({Done, CacheHit, mem_rd, Stall, DataOut}),
        40'({4'b1100, 16'h3333}));

    // conflict eviction
    adv(); Addr = 16'h0100; smp();
    chk("conf_miss", 40'({Stall, Done}), 40'b10);
    adv(); smp();
    chk("conf_maddr0", 40'(mem_addr), 40'h0100);
    wait_done("conf_done");
    chk("conf_data", 40'({CacheHit, DataOut}), 40'({1'b0, 16'hA0A0}));
    adv(); Addr = 16'h0000; smp();
    chk("evict_miss", 40'({Stall, Done}), 40'b10);
    wait_done("evict_done");
    chk("evict_data", 40'(DataOut), 40'h1111);

    // misaligned, then a normal aligned hit
    adv(); Addr = 16'h0003; smp();
    chk("misalign", 40'({err, Done, Stall, mem_rd, CacheHit, DataOut}),
        40'({5'b11000, 16'h0000}));
    adv(); Addr = 16'h0002; smp();
    chk("aligned_after", 40'({Done, CacheHit, err, DataOut}),
        40'({3'b110, 16'h2222}));

    // memory error on FILL2 word, N=3
    lat = 3; err_word = 2;
    adv(); Addr = 16'h0200; smp();
    chk("merr_stall", 40'(Stall), 40'd1);
    repeat (12) begin adv(); smp(); end
    chk("merr_c12", 40'({Stall, Done}), 40'b10);
    adv(); smp();
    chk("merr_done", 40'({Done, err, CacheHit}), 40'b110);
    adv(); err_word = -1; lat = 1; smp();
    chk("merr_remiss", 40'({Stall, Done}), 40'b10);
    wait_done("merr_refill");
    chk("merr_ok", 40'(err), 40'd0);
    adv(); smp();
    chk("merr_hit", 40'({Done, CacheHit}), 40'b11);

    // reset during FILL1
    adv(); Addr = 16'h0300; smp();
    chk("rst_miss", 40'(Stall), 40'd1);
    adv(); smp();
    chk("rst_fill0", 40'(mem_addr), 40'h0300);
    adv(); rst = 1; smp();
    adv(); rst = 0; smp();
    chk("rst_idle", 40'({mem_rd, Stall, Done}), 40'b010);
    adv(); smp();
    chk("rst_refill0", 40'({mem_rd, mem_addr}), 40'({1'b1, 16'h0300}));
    wait_done("rst_done");
    chk("rst_data", 40'(DataOut), 40'hC0C0);
    adv(); Addr = 16'h0000; smp();
    chk("rst_invalid", 40'({Stall, Done}), 40'b10);
    wait_done("rst_inv_done");

    // randomized traffic
    rand_mode = 1;
    for (int c = 0; c < 4000; c++) begin
      adv();
      rst = ($urandom_range(0, 299) == 0);
      Rd  = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 9) < 4) Addr = rand_addr();
    end
    adv(); rst = 0;
    repeat (4) adv();
    smp();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
